sad_best_match_tracker: RTL
===========================

// Module: sad_best_match_tracker
// PURPOSE
//  Tracks the best (minimum-SAD) candidate of a motion search for N_PART partitions in parallel.
//  Each partition keeps its own winning SAD and motion vector (MV).
//  Sits between the SAD tree and the mode decision stage of inter prediction.
//  Consumes one candidate beat per cycle and emits one result per search window via a valid/ready handshake.
// PARAMETERS
//  SAD_W   16  bit width of one SAD value (unsigned)
//  MV_W     8  bit width of one MV component (two's complement)
//  N_PART   4  partitions compared in parallel (1 = whole macroblock only)
//  CNT_W   12  width of the candidate counter (saturating)
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             reset, synchronous, active-low
//  in_valid   in   1             candidate beat valid
//  in_ready   out  1             block can accept a beat; equals !out_valid
//  in_first   in   1             beat is the first candidate of a search window
//  in_last    in   1             beat is the last candidate of a search window
//  in_sad     in   N_PART*SAD_W  per-partition SAD; partition p at [p*SAD_W +: SAD_W]
//  in_mvx     in   MV_W          candidate MV x, shared by all partitions
//  in_mvy     in   MV_W          candidate MV y, shared by all partitions
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts the result
//  out_sad    out  N_PART*SAD_W  per-partition minimum SAD
//  out_mvx    out  N_PART*MV_W   per-partition winning MV x
//  out_mvy    out  N_PART*MV_W   per-partition winning MV y
//  out_count  out  CNT_W         candidates accepted in the window; saturates at all-ones
// BEHAVIOUR
//  - Acceptance: a beat is accepted when in_valid && in_ready.
//  - Reset: state = IDLE, out_valid = 0, out_sad = all-ones, out_mv = 0, out_count = 0.
//  - FSM IDLE -> SEARCH: on any accepted beat that does not also carry in_last.
//  - FSM IDLE or SEARCH -> HOLD: on an accepted beat with in_last.
//  - FSM HOLD -> IDLE: on out_valid && out_ready.
//  - HOLD: out_valid = 1, in_ready = 0; output registers are frozen until the handshake.
//  - Window start: an accepted beat in IDLE, or any accepted beat with in_first, starts a window.
//    It loads its SAD/MV unconditionally into every partition and sets out_count = 1.
//    in_first in SEARCH therefore discards the partial window.
//  - Update rule (later beats), per partition p, the candidate replaces the winner when either:
//    a) sad < best_sad, or
//    b) sad == best_sad and |mvx|+|mvy| < best |mvx|+|mvy|.
//    On a full tie the earlier candidate is kept.
//  - MV magnitude: |mvx|+|mvy| computed in MV_W+1 bits. |-2^(MV_W-1)| = 2^(MV_W-1), no wrap.
//  - out_count increments by 1 per accepted beat and saturates at 2^CNT_W-1.
//  - Latency: out_valid rises the cycle after the in_last beat is accepted.
//    Results are registered, with no combinational path from in_* to out_*.
//  - A beat with in_first && in_last is a 1-candidate window: result = that beat, count = 1.
//  - out_ready is ignored while out_valid = 0.
//  - in_valid is ignored in HOLD; upstream must hold the beat until in_ready.
//  - rst_n low at any time, including mid-window or in HOLD, returns all state to reset values
//    on that edge. The partial result is discarded.
// STRUCTURE
//  - Package me_pkg: sad_t, mv_t typedefs; mv_mag() function (MV_W+1 result);
//    the SAD_MAX constant (all-ones).
//  - Sub-module sad_cand_lane: one per partition via generate.
//    It holds best SAD/MV and implements the load/compare/tie-break rule.
//  - Top level: FSM, handshake, counter, lane replication.
// TESTING
//  - Reset: out_valid = 0, in_ready = 1, out_sad = 16'hFFFF per lane, out_count = 0.
//  - 4 beats, SAD p0 = 50, 30, 40, 30; MVs (1,1), (2,0), (0,0), (0,1):
//    out_sad p0 = 30, MV = (0,1) by tie-break on magnitude; count = 4.
//  - Equal SAD 20 and equal magnitude, MVs (1,0) then (0,-1): earlier MV (1,0) is kept.
//  - out_ready held 0 for 5 cycles after the result: in_ready = 0 and outputs stable;
//    result released on the first out_ready = 1.
//  - in_first mid-window after SAD 5: a new window starting with SAD 90 reports 90, count restarts at 1.
//  - rst_n pulsed low in SEARCH after SAD 3: no out_valid.
//    The next window with single SAD 70 reports 70.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation best-match tracker.
//   SAD_W / MV_W : widths of one SAD value and one MV component
//   sad_t, mv_t  : SAD (unsigned) and MV component (two's complement) types
//   mag_t        : MV magnitude |mvx|+|mvy|, one bit wider than a component
//   SAD_MAX      : all-ones SAD, the "no winner yet" value
//   state_t      : tracker FSM states
//   mv_mag()     : |mvx|+|mvy| without wrap for the most negative component
package me_pkg;

  localparam int SAD_W = 16;
  localparam int MV_W  = 8;

  typedef logic [SAD_W-1:0]       sad_t;
  typedef logic signed [MV_W-1:0] mv_t;
  typedef logic [MV_W:0]          mag_t;

  localparam sad_t SAD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_HOLD
  } state_t;

  // Sign-extend to MV_W+1 bits before negating so that -2^(MV_W-1)
  // becomes +2^(MV_W-1) instead of wrapping back to itself.
  function automatic mag_t mv_mag(input mv_t x, input mv_t y);
    mag_t ax;
    mag_t ay;
    ax = {x[MV_W-1], x};
    ay = {y[MV_W-1], y};
    if (x[MV_W-1]) ax = -ax;
    if (y[MV_W-1]) ay = -ay;
    return ax + ay;
  endfunction

endpackage

// File: rtl/sad_cand_lane.sv
// One partition lane: holds the best SAD and its MV for the current window.
//   clk, rst_n          : clock, synchronous active-low reset
//   load                : window start, take the candidate unconditionally
//   update              : later beat, take the candidate only if it wins
//   cand_sad/mvx/mvy    : candidate SAD and MV
//   best_sad/mvx/mvy    : registered current winner
module sad_cand_lane
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             update,
  input  logic [SAD_W-1:0] cand_sad,
  input  logic [MV_W-1:0]  cand_mvx,
  input  logic [MV_W-1:0]  cand_mvy,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mvx,
  output logic [MV_W-1:0]  best_mvy
);

  logic [SAD_W-1:0] best_sad_reg;
  logic [MV_W-1:0]  best_mvx_reg;
  logic [MV_W-1:0]  best_mvy_reg;
  logic             cand_wins;

  // Strictly better SAD wins; equal SAD falls back to the smaller MV
  // magnitude. A full tie keeps the earlier candidate.
  always_comb begin
    cand_wins = 1'b0;
    if (cand_sad < best_sad_reg) begin
      cand_wins = 1'b1;
    end else if (cand_sad == best_sad_reg) begin
      cand_wins = mv_mag(cand_mvx, cand_mvy) < mv_mag(best_mvx_reg, best_mvy_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad_reg <= SAD_MAX;
      best_mvx_reg <= '0;
      best_mvy_reg <= '0;
    end else if (load || (update && cand_wins)) begin
      best_sad_reg <= cand_sad;
      best_mvx_reg <= cand_mvx;
      best_mvy_reg <= cand_mvy;
    end
  end

  assign best_sad = best_sad_reg;
  assign best_mvx = best_mvx_reg;
  assign best_mvy = best_mvy_reg;

endmodule

// File: rtl/sad_best_match_tracker.sv
// Best-match tracker: keeps the minimum-SAD candidate and its MV for
// N_PART partitions over a search window, then presents one result.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : candidate beat handshake (in_ready = !out_valid)
//   in_first/in_last           : window delimiters on the beat
//   in_sad                     : per-partition SAD, partition p at [p*SAD_W +: SAD_W]
//   in_mvx/in_mvy              : candidate MV shared by all partitions
//   out_valid/out_ready        : result handshake
//   out_sad/out_mvx/out_mvy    : per-partition winners
//   out_count                  : accepted beats in the window, saturating
module sad_best_match_tracker
  import me_pkg::*;
#(
  parameter int N_PART = 4,
  parameter int CNT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [N_PART*SAD_W-1:0] in_sad,
  input  logic [MV_W-1:0]         in_mvx,
  input  logic [MV_W-1:0]         in_mvy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_PART*SAD_W-1:0] out_sad,
  output logic [N_PART*MV_W-1:0]  out_mvx,
  output logic [N_PART*MV_W-1:0]  out_mvy,
  output logic [CNT_W-1:0]        out_count
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic             win_start;
  logic             win_update;

  // Handshake outputs depend on the state register only, so nothing on
  // in_* reaches out_* combinationally.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) state_next = in_last ? ST_HOLD : ST_SEARCH;
      end
      ST_SEARCH: begin
        if (in_valid && in_last) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  assign accept     = in_valid && in_ready;
  // in_first in SEARCH restarts the window and drops the partial result.
  assign win_start  = accept && ((state_reg == ST_IDLE) || in_first);
  assign win_update = accept && !win_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (win_start) begin
      count_reg <= CNT_W'(1);
    end else if (win_update && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out_count = count_reg;

  generate
    for (genvar gi = 0; gi < N_PART; gi++) begin : g_lane
      sad_cand_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (win_start),
        .update   (win_update),
        .cand_sad (in_sad[gi*SAD_W +: SAD_W]),
        .cand_mvx (in_mvx),
        .cand_mvy (in_mvy),
        .best_sad (out_sad[gi*SAD_W +: SAD_W]),
        .best_mvx (out_mvx[gi*MV_W +: MV_W]),
        .best_mvy (out_mvy[gi*MV_W +: MV_W])
      );
    end
  endgenerate

endmodule
